// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan with guard blanking and frame-synchronous double-buffered updates
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lead,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    pending,
  output logic                    frame_done
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [4*NUM_DIGITS-1:0] disp_v, disp_v_n, shd_v;
  logic [NUM_DIGITS-1:0] disp_dp, disp_dp_n, shd_dp, supp, an_n;
  logic slot_end, wrap, show, hi_zero, dp_n;
  logic [3:0] bcd_n;
  assign slot_end = cnt == CW'(REFRESH_DIV - 1);
  assign wrap = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign cnt_n = slot_end ? '0 : cnt + 1'b1;
  assign idx_n = wrap ? '0 : slot_end ? idx + 1'b1 : idx;
  assign disp_v_n = wrap ? (load ? value : pending ? shd_v : disp_v) : disp_v;
  assign disp_dp_n = wrap ? (load ? dp_in : pending ? shd_dp : disp_dp) : disp_dp;
  // outputs are computed from next-state values so they match the cycle's cnt/idx once registered
  always_comb begin
    hi_zero = 1'b1;
    supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero && disp_v_n[4*i +: 4] == 4'd0;
      supp[i] = blank_lead && hi_zero;
    end
  end
  assign show = cnt_n >= CW'(BLANK_CYCLES);
  assign bcd_n = 4'(disp_v_n >> {idx_n, 2'b00});
  assign an_n = show ? ~((NUM_DIGITS'(1) << idx_n) & ~supp) : '1;
  assign dp_n = show ? ~disp_dp_n[idx_n] : 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      disp_v <= '0;
      disp_dp <= '0;
      shd_v <= '0;
      shd_dp <= '0;
      pending <= 1'b0;
      frame_done <= 1'b0;
      bcd <= '0;
      an <= '1;
      dp <= 1'b1;
    end else begin
      cnt <= cnt_n;
      idx <= idx_n;
      disp_v <= disp_v_n;
      disp_dp <= disp_dp_n;
      if (load && !wrap) begin
        shd_v <= value;
        shd_dp <= dp_in;
      end
      pending <= wrap ? 1'b0 : load ? 1'b1 : pending;
      frame_done <= wrap;
      bcd <= bcd_n;
      an <= an_n;
      dp <= dp_n;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table, directed and random checks against a cycle-count based reference model
module tb_seg_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, blank_lead = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] bcd, an;
  logic dp, pending, frame_done;
  int total = 0, bad = 0;
  int t = 0;
  logic [15:0] m_disp = '0, m_shd = '0;
  logic [3:0] m_dp = '0, m_shddp = '0;
  logic m_pend = 1'b0, m_bl = 1'b0;
  typedef struct {
    int cyc;
    logic ld;
    logic [3:0] an;
    logic [3:0] bcd;
    logic dp;
    logic fd;
    logic pend;
  } vec_t;
  vec_t tbl[14];
  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lead(blank_lead), .bcd(bcd), .an(an), .dp(dp), .pending(pending),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  // expected {bcd, an, dp, pending, frame_done} straight from slot arithmetic on t
  function automatic logic [10:0] model_out();
    int d, ph;
    logic [3:0] b, a;
    logic p, sup;
    d = (t / 8) % 4;
    ph = t % 8;
    b = 4'(m_disp >> (4 * d));
    sup = m_bl && d > 0 && (m_disp >> (4 * d)) == 16'd0;
    a = (ph < 2 || sup) ? 4'hF : ~(4'b0001 << d);
    p = ph < 2 ? 1'b1 : ~m_dp[d];
    return {b, a, p, m_pend, t > 0 && t % 32 == 0};
  endfunction
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", n, t, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      t = 0; m_disp = '0; m_dp = '0; m_shd = '0; m_shddp = '0; m_pend = 1'b0;
    end else begin
      if (t % 32 == 31) begin
        if (load) begin m_disp = value; m_dp = dp_in; end
        else if (m_pend) begin m_disp = m_shd; m_dp = m_shddp; end
        m_pend = 1'b0;
      end else if (load) begin
        m_shd = value; m_shddp = dp_in; m_pend = 1'b1;
      end
      t++;
    end
    m_bl = blank_lead;
    @(negedge clk);
    chk("model", 32'({bcd, an, dp, pending, frame_done}), 32'(model_out()));
  endtask
  task automatic go_to(int c);
    while (t < c) tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (5) tick();
    rst_n = 1'b1;
  endtask
  task automatic load_at(int c, logic [15:0] v, logic [3:0] d);
    go_to(c);
    value = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic see(int c, string n, logic [3:0] a, logic [3:0] b);
    go_to(c);
    chk({n, "_an"}, 32'(an), 32'(a));
    chk({n, "_bcd"}, 32'(bcd), 32'(b));
  endtask
  initial begin
    tbl[0]  = '{0,  0, 4'hF, 4'h0, 1, 0, 0};
    tbl[1]  = '{2,  0, 4'hE, 4'h0, 1, 0, 0};
    tbl[2]  = '{5,  1, 4'hE, 4'h0, 1, 0, 0};
    tbl[3]  = '{6,  0, 4'hE, 4'h0, 1, 0, 1};
    tbl[4]  = '{8,  0, 4'hF, 4'h0, 1, 0, 1};
    tbl[5]  = '{10, 0, 4'hD, 4'h0, 1, 0, 1};
    tbl[6]  = '{31, 0, 4'h7, 4'h0, 1, 0, 1};
    tbl[7]  = '{32, 0, 4'hF, 4'h4, 1, 1, 0};
    tbl[8]  = '{33, 0, 4'hF, 4'h4, 1, 0, 0};
    tbl[9]  = '{34, 0, 4'hE, 4'h4, 1, 0, 0};
    tbl[10] = '{42, 0, 4'hD, 4'h3, 1, 0, 0};
    tbl[11] = '{50, 0, 4'hB, 4'h2, 1, 0, 0};
    tbl[12] = '{58, 0, 4'h7, 4'h1, 1, 0, 0};
    tbl[13] = '{59, 0, 4'h7, 4'h1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      go_to(tbl[i].cyc);
      chk("tbl", 32'({an, bcd, dp, frame_done, pending}),
          32'({tbl[i].an, tbl[i].bcd, tbl[i].dp, tbl[i].fd, tbl[i].pend}));
      if (tbl[i].ld) begin
        value = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
      end
    end
    load_at(63, 16'hABCD, 4'b0000);
    chk("wrap_load", 32'({bcd, pending, frame_done}), 32'({4'hD, 1'b0, 1'b1}));
    load_at(95, 16'h1234, 4'b0100);
    load_at(100, 16'h9999, 4'b0000);
    go_to(106); chk("dp_idx1", 32'(dp), 32'(1));
    go_to(112); chk("dp_blank", 32'(dp), 32'(1));
    go_to(114); chk("dp_idx2", 32'(dp), 32'(0));
    go_to(116);
    chk("pend_before_rst", 32'(pending), 32'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst", 32'({bcd, an, dp, frame_done, pending}), 32'({4'h0, 4'hF, 1'b1, 1'b0, 1'b0}));
    see(34, "rst_discard", 4'hE, 4'h0);
    do_reset();
    load_at(3, 16'h1111, 4'b0000);
    load_at(20, 16'h2222, 4'b0000);
    chk("last_pend", 32'(pending), 32'(1));
    see(34, "lw0", 4'hE, 4'h2);
    see(42, "lw1", 4'hD, 4'h2);
    see(50, "lw2", 4'hB, 4'h2);
    see(58, "lw3", 4'h7, 4'h2);
    do_reset();
    blank_lead = 1'b1;
    load_at(0, 16'h0050, 4'b0000);
    see(4, "lz0_d0", 4'hE, 4'h0);
    see(12, "lz0_d1", 4'hF, 4'h0);
    see(20, "lz0_d2", 4'hF, 4'h0);
    see(28, "lz0_d3", 4'hF, 4'h0);
    see(36, "lz1_d0", 4'hE, 4'h0);
    see(44, "lz1_d1", 4'hD, 4'h5);
    see(52, "lz1_d2", 4'hF, 4'h0);
    see(60, "lz1_d3", 4'hF, 4'h0);
    blank_lead = 1'b0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      load = $urandom_range(5) == 0;
      value = 16'($urandom);
      if ($urandom_range(3) == 0) value[15:8] = 8'h00;
      dp_in = 4'($urandom);
      if ($urandom_range(150) == 0) blank_lead = ~blank_lead;
      rst_n = $urandom_range(700) != 0;
      tick();
    end
    load = 1'b0;
    rst_n = 1'b1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
